// File: rtl/bin_stream_gen_pkg.sv
// rtl/bin_stream_gen_pkg.sv - FSM state encodings and sizing helpers for bin_stream_gen
package bin_stream_gen_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_VBLK = 2'd1;
    localparam logic [1:0] ST_HACT = 2'd2;
    localparam logic [1:0] ST_HBLK = 2'd3;

    // Counter width for a counter that walks 0..range_n-1, never narrower than one bit.
    function automatic int cnt_width(input int range_n);
        return (range_n <= 2) ? 1 : $clog2(range_n);
    endfunction

    // Checkerboard of 8x8 squares: x[3] ^ y[3].
    function automatic logic checker_bit(input int x, input int y);
        return ((x ^ y) & 8) != 0;
    endfunction

endpackage

// File: rtl/bin_word_serializer.sv
// rtl/bin_word_serializer.sv - holding register, LSB-first shift register, src handshake and underflow flag
module bin_word_serializer (
    input  logic       clk,
    input  logic       rst,
    input  logic       block_i,
    input  logic       load_i,
    input  logic       adv_i,
    input  logic [7:0] src_data_i,
    input  logic       src_valid_i,
    output logic       src_ready_o,
    output logic       bit_o,
    output logic       underflow_o
);

    logic [7:0] hold_q;
    logic       hold_full_q;
    logic [7:0] shift_q;
    logic       underflow_q;
    logic       take;
    logic       xfer;

    // A boundary load only happens when the frame is fed from src_data.
    assign take        = load_i & ~block_i;
    assign src_ready_o = ~rst & ~hold_full_q & ~block_i;
    assign xfer        = src_valid_i & src_ready_o;

    // Holding register: a new word can only land when empty, so a same-edge load always sees the old word.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
        end else if (xfer) begin
            hold_q      <= src_data_i;
            hold_full_q <= 1'b1;
        end else if (take) begin
            hold_full_q <= 1'b0;
        end
    end

    // Shift register feeds the pixel output; an empty holding register at a boundary yields zeros and flags underflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q     <= 8'h00;
            underflow_q <= 1'b0;
        end else if (take) begin
            shift_q <= hold_full_q ? hold_q : 8'h00;
            if (!hold_full_q) begin
                underflow_q <= 1'b1;
            end
        end else if (adv_i) begin
            shift_q <= {1'b0, shift_q[7:1]};
        end else begin
            shift_q <= 8'h00;
        end
    end

    assign bit_o       = shift_q[0];
    assign underflow_o = underflow_q;

endmodule

// File: rtl/bin_stream_gen.sv
// rtl/bin_stream_gen.sv - binary video transmit timing (vsync/href/bit); BIN_TEST_PATTERN_EN adds a checkerboard source
module bin_stream_gen
    import bin_stream_gen_pkg::*;
#(
    parameter int IMG_H_DISP    = 640,
    parameter int IMG_V_DISP    = 480,
    parameter int H_BLANK       = 160,
    parameter int V_BLANK_LINES = 45
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       pattern_en,
    input  logic [7:0] src_data,
    input  logic       src_valid,
    output logic       src_ready,
    output logic       post_img_vsync,
    output logic       post_img_href,
    output logic       post_img_bit,
    output logic       frame_done,
    output logic       underflow
);

    localparam int H_TOTAL = IMG_H_DISP + H_BLANK;
    localparam int L_MAX   = (IMG_V_DISP > V_BLANK_LINES) ? IMG_V_DISP : V_BLANK_LINES;
    localparam int PW      = cnt_width(H_TOTAL);
    localparam int LW      = cnt_width(L_MAX);

    localparam logic [PW-1:0] PIX_LAST  = PW'(H_TOTAL - 1);
    localparam logic [PW-1:0] ACT_LAST  = PW'(IMG_H_DISP - 1);
    localparam logic [LW-1:0] VB_LAST   = LW'(V_BLANK_LINES - 1);
    localparam logic [LW-1:0] LINE_LAST = LW'(IMG_V_DISP - 1);

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] pix_q, pix_d;
    logic [LW-1:0] line_q, line_d;
    logic          pattern_q, pattern_d;
    logic          pat_bit_q, pat_bit_d;
    logic          vsync_q, href_q, done_q;
    logic          frame_end, frame_start;
    logic          ser_load, ser_adv, ser_bit;

    // Frame sequencer: the line counter counts blanking lines in VBLK and active lines otherwise.
    always_comb begin
        state_d     = state_q;
        pix_d       = pix_q;
        line_d      = line_q;
        pattern_d   = pattern_q;
        frame_end   = 1'b0;
        frame_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                pix_d  = '0;
                line_d = '0;
                if (enable) begin
                    state_d     = ST_VBLK;
                    frame_start = 1'b1;
                end
            end
            ST_VBLK: begin
                if (pix_q == PIX_LAST) begin
                    pix_d = '0;
                    if (line_q == VB_LAST) begin
                        line_d  = '0;
                        state_d = ST_HACT;
                    end else begin
                        line_d = line_q + LW'(1);
                    end
                end else begin
                    pix_d = pix_q + PW'(1);
                end
            end
            ST_HACT: begin
                pix_d = pix_q + PW'(1);
                if (pix_q == ACT_LAST) begin
                    state_d = ST_HBLK;
                end
            end
            ST_HBLK: begin
                if (pix_q == PIX_LAST) begin
                    pix_d = '0;
                    if (line_q == LINE_LAST) begin
                        frame_end = 1'b1;
                        line_d    = '0;
                        if (enable) begin
                            state_d     = ST_VBLK;
                            frame_start = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        line_d  = line_q + LW'(1);
                        state_d = ST_HACT;
                    end
                end else begin
                    pix_d = pix_q + PW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
`ifdef BIN_TEST_PATTERN_EN
        if (frame_start) begin
            pattern_d = pattern_en;
        end
        pat_bit_d = (state_d == ST_HACT) && pattern_d && checker_bit(int'(pix_d), int'(line_d));
`else
        pat_bit_d = 1'b0;
`endif
    end

`ifndef BIN_TEST_PATTERN_EN
    logic unused_pattern_en;
    assign unused_pattern_en = pattern_en;
`endif

    // Outputs are registered from next state so href, vsync and the first pixel rise together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pix_q     <= '0;
            line_q    <= '0;
            pattern_q <= 1'b0;
            pat_bit_q <= 1'b0;
            vsync_q   <= 1'b0;
            href_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pix_q     <= pix_d;
            line_q    <= line_d;
            pattern_q <= pattern_d;
            pat_bit_q <= pat_bit_d;
            vsync_q   <= (state_d == ST_HACT) || (state_d == ST_HBLK);
            href_q    <= (state_d == ST_HACT);
            done_q    <= frame_end;
        end
    end

    assign ser_load = (state_d == ST_HACT) && (pix_d[2:0] == 3'b000);
    assign ser_adv  = (state_d == ST_HACT);

    bin_word_serializer u_ser (
        .clk         (clk),
        .rst         (rst),
        .block_i     (pattern_q),
        .load_i      (ser_load),
        .adv_i       (ser_adv),
        .src_data_i  (src_data),
        .src_valid_i (src_valid),
        .src_ready_o (src_ready),
        .bit_o       (ser_bit),
        .underflow_o (underflow)
    );

    assign post_img_vsync = vsync_q;
    assign post_img_href  = href_q;
    assign post_img_bit   = ser_bit | pat_bit_q;
    assign frame_done     = done_q;

endmodule

// File: tb/tb_bin_stream_gen.sv
// tb/tb_bin_stream_gen.sv - randomized self-checking bench for bin_stream_gen against a frame-position model
module tb_bin_stream_gen;

    localparam int IMG_H = 16;
    localparam int IMG_V = 4;
    localparam int HB    = 4;
    localparam int VBL   = 2;
    localparam int HT    = IMG_H + HB;
    localparam int VBC   = VBL * HT;
    localparam int FRAME = VBC + IMG_V * HT;
`ifdef BIN_TEST_PATTERN_EN
    localparam bit PAT_EN = 1'b1;
`else
    localparam bit PAT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       pattern_en = 1'b0;
    logic [7:0] src_data = 8'h00;
    logic       src_valid = 1'b0;
    logic       src_ready, post_img_vsync, post_img_href, post_img_bit, frame_done, underflow;

    int errors = 0;
    int checks = 0;
    int mode = 0;
    logic rdy_s = 1'b0;

    bin_stream_gen #(
        .IMG_H_DISP(IMG_H), .IMG_V_DISP(IMG_V), .H_BLANK(HB), .V_BLANK_LINES(VBL)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .pattern_en(pattern_en),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .post_img_vsync(post_img_vsync), .post_img_href(post_img_href),
        .post_img_bit(post_img_bit), .frame_done(frame_done), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: position within the frame, one-word buffer and the byte currently on the wire.
    bit       m_run = 0, m_pat = 0, m_fd = 0, m_hfull = 0, m_uf = 0;
    int       m_t = 0;
    bit [7:0] m_hold = 0, m_cur = 0;

    always @(posedge clk) begin : model
        bit run_n, pat_n, fd_n, hf_n, uf_n, xfer;
        int t_n, x;
        bit [7:0] hold_n, cur_n;
        run_n = m_run; t_n = m_t; pat_n = m_pat; fd_n = 0;
        hf_n = m_hfull; uf_n = m_uf; hold_n = m_hold; cur_n = m_cur;
        if (rst) begin
            run_n = 0; t_n = 0; pat_n = 0; hf_n = 0; uf_n = 0; cur_n = 0;
        end else begin
            xfer = src_valid && !m_hfull && !m_pat;
            if (!m_run) begin
                if (enable) begin
                    run_n = 1; t_n = 0; pat_n = PAT_EN && pattern_en;
                end
            end else if (m_t == FRAME - 1) begin
                fd_n = 1;
                t_n  = 0;
                if (enable) pat_n = PAT_EN && pattern_en;
                else run_n = 0;
            end else begin
                t_n = m_t + 1;
            end
            if (run_n && t_n >= VBC) begin
                x = (t_n - VBC) % HT;
                if (x < IMG_H && x % 8 == 0 && !pat_n) begin
                    cur_n = m_hfull ? m_hold : 8'h00;
                    if (!m_hfull) uf_n = 1;
                    hf_n = 0;
                end
            end
            if (xfer) begin
                hold_n = src_data;
                hf_n   = 1;
            end
        end
        m_run <= run_n; m_t <= t_n; m_pat <= pat_n; m_fd <= fd_n;
        m_hfull <= hf_n; m_uf <= uf_n; m_hold <= hold_n; m_cur <= cur_n;
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin : compare
        bit ev, eh, eb, er;
        int x, ln;
        ev = m_run && (m_t >= VBC);
        x  = ev ? (m_t - VBC) % HT : 0;
        ln = ev ? (m_t - VBC) / HT : 0;
        eh = ev && (x < IMG_H);
        eb = eh && (m_pat ? (((x ^ ln) & 8) != 0) : m_cur[x % 8]);
        er = !rst && !m_hfull && !m_pat;
        check("vsync", post_img_vsync, ev);
        check("href", post_img_href, eh);
        check("bit", post_img_bit, eb);
        check("frame_done", frame_done, m_fd);
        check("underflow", underflow, m_uf);
        check("src_ready", src_ready, er);
    end

    task automatic tick();
        @(negedge clk);
        rdy_s = src_ready;
        @(posedge clk);
        #2;
        case (mode)
            1: begin src_valid = 1'b1; src_data = 8'hA5; end
            2: begin src_valid = !(m_run && m_t >= VBC && m_t < VBC + 8); src_data = 8'hA5; end
            3: begin
                if (src_valid && rdy_s) src_data = src_data + 8'd1;
                src_valid = !src_valid;
            end
            4: begin src_valid = ($urandom_range(3) != 0); src_data = 8'($urandom); end
            default: ;
        endcase
    endtask

    task automatic wait_pos(input int t, input string name);
        int n = 0;
        while (!(m_run && m_t == t) && n < 400) begin tick(); n++; end
        if (!(m_run && m_t == t)) begin
            checks++; errors++;
            $display("FAIL %s: frame position %0d never reached", name, t);
        end
    endtask

    task automatic wait_href(output int n);
        n = 0;
        do begin tick(); n++; end while (!post_img_href && n < 300);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin tick(); n++; end while (!frame_done && n < 300);
    endtask

    initial begin
        int n;
        logic [15:0] line_bits;
        repeat (3) tick();
        check("rst_vsync", post_img_vsync, 0);
        check("rst_href", post_img_href, 0);
        check("rst_done", frame_done, 0);
        check("rst_uf", underflow, 0);
        check("rst_ready", src_ready, 0);
        rst = 0;

        // Constant A5 source.
        mode = 1; enable = 1;
        wait_href(n);
        check("first_href_latency", n, 41);
        line_bits[0] = post_img_bit;
        for (int i = 1; i < 16; i++) begin tick(); line_bits[i] = post_img_bit; end
        check("line0_a5", line_bits, 16'hA5A5);
        wait_done(n);
        wait_done(n);
        check("frame_period", n, FRAME);
        check("no_uf_a5", underflow, 0);

        // Starve the second byte of line 0 for one frame.
        wait_pos(0, "starve_start");
        mode = 2; tick();
        wait_pos(0, "starve_end");
        mode = 1;
        check("uf_set", underflow, 1);
        repeat (FRAME) tick();
        check("uf_sticky", underflow, 1);

        // Toggling valid with incrementing bytes after a reset.
        rst = 1; tick(); tick();
        rst = 0; mode = 3; src_valid = 0; src_data = 0;
        repeat (2 * FRAME + 50) tick();
        check("toggle_no_uf", underflow, 0);

        // Drop enable mid-frame.
        wait_pos(60, "en_drop");
        enable = 0;
        wait_done(n);
        check("done_after_drop", frame_done, 1);
        n = 0;
        repeat (40) begin tick(); n += frame_done; end
        check("idle_no_done", n, 0);
        check("idle_vsync", post_img_vsync, 0);
        check("idle_href", post_img_href, 0);

        // Random source, reset in HACT of line 2.
        enable = 1; mode = 4;
        wait_pos(VBC + 2 * HT + 5, "rst_point");
        rst = 1; tick();
        check("mid_rst_vsync", post_img_vsync, 0);
        check("mid_rst_href", post_img_href, 0);
        check("mid_rst_bit", post_img_bit, 0);
        check("mid_rst_uf", underflow, 0);
        rst = 0;
        wait_href(n);
        check("rst_href_latency", n, 41);
        repeat (2 * FRAME) tick();

`ifdef BIN_TEST_PATTERN_EN
        pattern_en = 1; tick();
        wait_pos(0, "pat_start");
        pattern_en = 0;
        wait_pos(VBC, "pat_line0");
        line_bits[0] = post_img_bit;
        for (int i = 1; i < 16; i++) begin tick(); line_bits[i] = post_img_bit; end
        check("pattern_line0", line_bits, 16'hFF00);
        check("pattern_ready", src_ready, 0);
        repeat (2 * FRAME) tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
